// File: rtl/scene_fader.sv
// ---------------------------------------------------------------------------
// scene_fader
//
// Frame-synchronous cross-fade between screen states. It sits between the
// game-state FSM and the picture mux / VGA controller. When the requested
// screen state changes, the picture is dimmed to black one brightness step
// at a time. The displayed state is swapped while the screen is black, and
// the picture is then brought back up to full brightness. Screen changes
// therefore always land on a frame boundary and never cut mid-frame.
//
// Build option:
//   SCENE_FADE_EN  defined   -> full fade engine (FSM, step counter, scaler)
//   SCENE_FADE_EN  undefined -> state_out is a one-cycle registered copy of
//                               state_in, pix_out = pix_in, fade_busy = 0
//
// Parameters:
//   STEP_FRAMES  frames spent on each brightness step (>= 1)
//   LVL_MAX      full-brightness level (fixed at 16, scaling shift is 4)
//
// Ports:
//   vga_clk    in   pixel clock
//   sys_rst_n  in   asynchronous active-low reset
//   state_in   in   [1:0]  requested screen state from the game FSM
//   pix_x      in   [9:0]  current pixel column from vga_ctrl
//   pix_y      in   [9:0]  current pixel row from vga_ctrl
//   pix_in     in   [15:0] RGB565 pixel from the picture mux
//   state_out  out  [1:0]  displayed screen state (picture-mux select)
//   pix_out    out  [15:0] brightness-scaled RGB565 to vga_ctrl
//   fade_busy  out         high while a fade is in progress
// ---------------------------------------------------------------------------
module scene_fader #(
    parameter int STEP_FRAMES = 2,
    parameter int LVL_MAX     = 16
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  state_in,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] pix_in,
    output logic [1:0]  state_out,
    output logic [15:0] pix_out,
    output logic        fade_busy
);

`ifdef SCENE_FADE_EN

    localparam int              STEP_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);
    localparam logic [4:0]      LVL_FULL  = 5'(LVL_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_e;

    // Scales each RGB565 channel by lvl/16. Products are kept at full
    // width (10/11/10 bits) so lvl = 16 reproduces the input exactly.
    function automatic logic [15:0] scale_rgb565(input logic [15:0] pix,
                                                 input logic [4:0]  lvl);
        logic [9:0]  r_prod;
        logic [10:0] g_prod;
        logic [9:0]  b_prod;
        r_prod = 10'(pix[15:11]) * 10'(lvl);
        g_prod = 11'(pix[10:5])  * 11'(lvl);
        b_prod = 10'(pix[4:0])   * 10'(lvl);
        return {5'(r_prod >> 4), 6'(g_prod >> 4), 5'(b_prod >> 4)};
    endfunction

    fade_state_e       state_q, state_d;
    logic [4:0]        lvl_q, lvl_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        state_out_q, state_out_d;
    logic              busy_q, busy_d;
    logic              origin_q, origin_d;

    logic              frame_tick;
    logic              retarget;
    logic              step_wrap;

    // Frame tick: rising edge of "raster at (0,0)", so a raster that
    // lingers on the origin for several cycles still ticks only once.
    assign origin_d   = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign frame_tick = origin_d && !origin_q;

    assign retarget   = (state_in != state_out_q);
    assign step_wrap  = (step_q == STEP_LAST);

    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        step_d      = step_q;
        state_out_d = state_out_q;

        case (state_q)
            IDLE: begin
                // A tick in the same cycle as the request is deliberately
                // ignored; counting starts from the next tick.
                if (retarget) begin
                    state_d = FADE_OUT;
                    step_d  = '0;
                end
            end

            FADE_OUT: begin
                if (lvl_q == 5'd0) begin
                    // Reached when a fade-in is interrupted before its
                    // first increment: already black, go straight to swap.
                    state_d = SWAP;
                end else if (frame_tick) begin
                    if (step_wrap) begin
                        step_d = '0;
                        lvl_d  = lvl_q - 5'd1;
                        if (lvl_q == 5'd1) begin
                            state_d = SWAP;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end

            SWAP: begin
                // Picks up whatever state_in is now, which may differ from
                // the value that started the fade (or equal the old one).
                if (frame_tick) begin
                    state_out_d = state_in;
                    step_d      = '0;
                    state_d     = FADE_IN;
                end
            end

            FADE_IN: begin
                if (retarget) begin
                    state_d = FADE_OUT;
                    step_d  = '0;
                end else if (frame_tick) begin
                    if (step_wrap) begin
                        step_d = '0;
                        lvl_d  = lvl_q + 5'd1;
                        if (lvl_q == LVL_FULL - 5'd1) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                lvl_d   = LVL_FULL;
                step_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            lvl_q       <= LVL_FULL;
            step_q      <= '0;
            state_out_q <= 2'd0;
            busy_q      <= 1'b0;
            origin_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            step_q      <= step_d;
            state_out_q <= state_out_d;
            busy_q      <= busy_d;
            origin_q    <= origin_d;
        end
    end

    // Zero-latency scaling; lvl only moves right after a frame tick, so a
    // frame is rendered at a single level (pixel (0,0) may keep the old one).
    assign pix_out   = scale_rgb565(pix_in, lvl_q);
    assign state_out = state_out_q;
    assign fade_busy = busy_q;

`else

    logic [1:0] state_out_q;
    logic       unused_inputs;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_out_q <= 2'd0;
        end else begin
            state_out_q <= state_in;
        end
    end

    // Raster position and fade parameters have no function without the
    // fade engine; fold them into a sink so they stay visibly consumed.
    assign unused_inputs = ^{pix_x, pix_y} ^ (STEP_FRAMES == 0) ^ (LVL_MAX == 0);

    assign pix_out   = pix_in;
    assign state_out = state_out_q;
    assign fade_busy = 1'b0;

`endif

endmodule

// File: tb/tb_scene_fader.sv
module tb_scene_fader;

    localparam int STEP = 2;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  state_in;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_in;
    logic [1:0]  state_out;
    logic [15:0] pix_out;
    logic        fade_busy;

    int passed = 0;
    int total  = 0;
    int ticks  = 0;

    scene_fader #(.STEP_FRAMES(STEP), .LVL_MAX(16)) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .state_in (state_in),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_in   (pix_in),
        .state_out(state_out),
        .pix_out  (pix_out),
        .fade_busy(fade_busy)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One pixel clock on a 16x8 synthetic raster; counts frame ticks, i.e.
    // edges at which the raster presented (0,0).
    task automatic cyc();
        logic tk;
        tk = (pix_x == 10'd0) && (pix_y == 10'd0);
        @(posedge vga_clk);
        #1;
        if (tk) ticks++;
        if (pix_x == 10'd15) begin
            pix_x = 10'd0;
            pix_y = (pix_y == 10'd7) ? 10'd0 : 10'(pix_y + 10'd1);
        end else begin
            pix_x = 10'(pix_x + 10'd1);
        end
    endtask

`ifdef SCENE_FADE_EN
    // Reference brightness scaling: each channel times lvl/16, truncated.
    function automatic logic [15:0] ref_scale(input logic [15:0] p, input int lvl);
        int r, g, b;
        r = (int'(p[15:11]) * lvl) / 16;
        g = (int'(p[10:5])  * lvl) / 16;
        b = (int'(p[4:0])   * lvl) / 16;
        return 16'((r << 11) | (g << 5) | b);
    endfunction

    // Level after n counted ticks of an uninterrupted transition.
    function automatic int exp_lvl(input int n);
        if (n <= 16 * STEP) return 16 - n / STEP;
        if (n == 16 * STEP + 1) return 0;
        return ((n - 16 * STEP - 1) / STEP > 16) ? 16 : (n - 16 * STEP - 1) / STEP;
    endfunction

    task automatic run_ticks(input int n);
        int start;
        int guard;
        start = ticks;
        guard = 0;
        while (ticks < start + n && guard < 200 * n + 200) begin
            cyc();
            guard++;
        end
        if (ticks < start + n) begin
            total++;
            $error("FAIL tick_timeout: observed %0d ticks expected %0d", ticks - start, n);
        end
    endtask

    task automatic check_pix(input string tag, input int lvl);
        pix_in = 16'($urandom);
        #1;
        chk(tag, 32'(pix_out), 32'(ref_scale(pix_in, lvl)));
    endtask
`endif

    initial begin
        sys_rst_n = 1'b0;
        state_in  = 2'd0;
        pix_x     = 10'd3;
        pix_y     = 10'd2;
        pix_in    = 16'hFFFF;
        #12;
        chk("rst_pix", 32'(pix_out), 32'h0000FFFF);
        chk("rst_busy", 32'(fade_busy), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        sys_rst_n = 1'b1;
        cyc(); cyc(); cyc();

`ifdef SCENE_FADE_EN
        // Full transition 0 -> 1
        state_in = 2'd1;
        cyc();
        chk("busy_rise", 32'(fade_busy), 32'd1);
        ticks = 0;
        for (int n = 1; n <= 16 * STEP * 2 + 1; n++) begin
            run_ticks(1);
            check_pix($sformatf("full_lvl_t%0d", n), exp_lvl(n));
            chk($sformatf("full_state_t%0d", n), 32'(state_out), (n >= 16 * STEP + 1) ? 32'd1 : 32'd0);
            chk($sformatf("full_busy_t%0d", n), 32'(fade_busy), (n < 32 * STEP + 1) ? 32'd1 : 32'd0);
            if (n == STEP || n == 32 * STEP + 1) begin
                pix_in = 16'hFFFF;
                #1;
                chk($sformatf("full_white_t%0d", n), 32'(pix_out), 32'(ref_scale(16'hFFFF, exp_lvl(n))));
            end
        end

        // Retarget during fade-out: latest request wins at the swap
        state_in = 2'd2;
        cyc();
        ticks = 0;
        run_ticks(10);
        state_in = 2'd3;
        run_ticks(16 * STEP - 10);
        check_pix("retgt_black", 0);
        chk("retgt_state_pre", 32'(state_out), 32'd1);
        run_ticks(1);
        chk("retgt_state", 32'(state_out), 32'd3);
        run_ticks(16 * STEP - 1);
        chk("retgt_busy_64", 32'(fade_busy), 32'd1);
        run_ticks(1);
        chk("retgt_busy_65", 32'(fade_busy), 32'd0);
        check_pix("retgt_full", 16);

        // Interrupt during fade-in at level 8
        state_in = 2'd0;
        cyc();
        ticks = 0;
        run_ticks(16 * STEP + 1 + 8 * STEP);
        check_pix("intr_lvl8", 8);
        chk("intr_state0", 32'(state_out), 32'd0);
        state_in = 2'd2;
        cyc();
        chk("intr_busy", 32'(fade_busy), 32'd1);
        ticks = 0;
        run_ticks(STEP);
        check_pix("intr_lvl7", 7);
        run_ticks(8 * STEP - STEP);
        check_pix("intr_black", 0);
        chk("intr_state_pre", 32'(state_out), 32'd0);
        run_ticks(1);
        chk("intr_state2", 32'(state_out), 32'd2);
        run_ticks(16 * STEP);
        chk("intr_done", 32'(fade_busy), 32'd0);
        check_pix("intr_full", 16);

        // Asynchronous reset at level 5
        state_in = 2'd1;
        cyc();
        ticks = 0;
        run_ticks(11 * STEP);
        check_pix("arst_lvl5", 5);
        pix_in = 16'($urandom);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_busy", 32'(fade_busy), 32'd0);
        chk("arst_pix", 32'(pix_out), 32'(pix_in));
        sys_rst_n = 1'b1;
        cyc();
        chk("arst_refade", 32'(fade_busy), 32'd1);
`else
        begin
            logic [1:0] exp_so;
            logic [1:0] nxt;
            chk("off_state0", 32'(state_out), 32'd0);
            state_in = 2'd2;
            #1;
            chk("off_lat_hold", 32'(state_out), 32'd0);
            cyc();
            chk("off_lat_one", 32'(state_out), 32'd2);
            exp_so = 2'd2;
            for (int i = 0; i < 30; i++) begin
                nxt      = 2'($urandom);
                state_in = nxt;
                pix_in   = 16'($urandom);
                #1;
                chk($sformatf("off_hold_%0d", i), 32'(state_out), 32'(exp_so));
                chk($sformatf("off_pix_%0d", i), 32'(pix_out), 32'(pix_in));
                cyc();
                exp_so = nxt;
                chk($sformatf("off_state_%0d", i), 32'(state_out), 32'(exp_so));
                chk($sformatf("off_busy_%0d", i), 32'(fade_busy), 32'd0);
            end
            state_in = 2'd3;
            cyc();
            chk("off_pre_rst", 32'(state_out), 32'd3);
            #2;
            sys_rst_n = 1'b0;
            #1;
            chk("off_arst_state", 32'(state_out), 32'd0);
            chk("off_arst_busy", 32'(fade_busy), 32'd0);
            sys_rst_n = 1'b1;
            cyc();
            chk("off_after_rst", 32'(state_out), 32'd3);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
